// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and default sizes/timing for the SRAM port controller
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_ACCESS_CYC = 2;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/sram_io_buf.sv
// rtl/sram_io_buf.sv - tri-state SRAM data pad
// Ports:
//   i_drive_en  1 = drive i_dout onto io_pad, 0 = high-Z
//   i_dout      outgoing write data
//   o_din       value currently seen on the pad
//   io_pad      bidirectional SRAM data pins
module sram_io_buf #(
  parameter int DATA_W = 8
) (
  input  logic              i_drive_en,
  input  logic [DATA_W-1:0] i_dout,
  output logic [DATA_W-1:0] o_din,
  inout  wire  [DATA_W-1:0] io_pad
);

  assign io_pad = i_drive_en ? i_dout : {DATA_W{1'bz}};
  assign o_din  = io_pad;

endmodule

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - single-byte request/response front end that owns the SRAM pins
// Ports:
//   CLOCK_50, rst                  clock, async active-high reset
//   req_valid/ready/write/addr/wdata  request handshake, fields sampled on accept
//   rsp_valid, rsp_rdata           one-cycle read response pulse and held read byte
//   busy                           high outside IDLE
//   sram_adrx/data/nCS/nOE/nWE     registered SRAM pins
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_adrx,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_nCS,
  output logic              sram_nOE,
  output logic              sram_nWE
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (ACCESS_CYC < 1 || ACCESS_CYC > 15) begin : g_bad_access
    $error("ACCESS_CYC must be in 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_adrx;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rsp_valid;
  logic              r_ncs, r_noe, r_nwe, r_drive_en;

  logic              w_accept, w_write_nxt, w_sample;
  logic              w_ncs_nxt, w_noe_nxt, w_nwe_nxt, w_de_nxt, w_rsp_nxt;
  logic [DATA_W-1:0] w_din;

  assign req_ready = (r_state == IDLE) && !rst;
  assign busy      = (r_state != IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = ACCESS_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) w_state_nxt = HOLD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pin values are computed from the next state and registered, so each pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    w_write_nxt = w_accept ? req_write : r_write;
    w_ncs_nxt   = (w_state_nxt == IDLE);
    w_noe_nxt   = !(!w_write_nxt && (w_state_nxt == SETUP || w_state_nxt == ACCESS));
    w_nwe_nxt   = !(w_write_nxt && (w_state_nxt == ACCESS));
    // Write data stays on the bus through HOLD so it outlasts the nWE rise.
    w_de_nxt    = w_write_nxt && (w_state_nxt != IDLE);
    w_rsp_nxt   = !w_write_nxt && (w_state_nxt == HOLD);
    w_sample    = (r_state == ACCESS) && (r_cnt == '0) && !r_write;
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_adrx      <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_ncs       <= 1'b1;
      r_noe       <= 1'b1;
      r_nwe       <= 1'b1;
      r_drive_en  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_nxt;
      r_ncs       <= w_ncs_nxt;
      r_noe       <= w_noe_nxt;
      r_nwe       <= w_nwe_nxt;
      r_drive_en  <= w_de_nxt;
      // Address only moves on accept, while nCS is still high.
      if (w_accept) begin
        r_write <= req_write;
        r_wdata <= req_wdata;
        r_adrx  <= req_addr;
      end
      if (w_sample) r_rdata <= w_din;
    end
  end

  sram_io_buf #(.DATA_W(DATA_W)) u_io_buf (
    .i_drive_en (r_drive_en),
    .i_dout     (r_wdata),
    .o_din      (w_din),
    .io_pad     (sram_data)
  );

  assign sram_adrx = r_adrx;
  assign sram_nCS  = r_ncs;
  assign sram_nOE  = r_noe;
  assign sram_nWE  = r_nwe;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - scoreboard bench for sram_port_ctrl at default and stretched timing
module tb_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [10:0] req_addr  = '0;
  logic [7:0]  req_wdata = '0;
  int          sel = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          last_t = 0;

  typedef struct { logic [7:0] d; int c; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic v0, v1;
  assign v0 = req_valid && (sel == 0);
  assign v1 = req_valid && (sel == 1);

  logic        rdy0, rsp0, busy0, ncs0, noe0, nwe0;
  logic        rdy1, rsp1, busy1, ncs1, noe1, nwe1;
  logic [7:0]  rd0, rd1;
  logic [10:0] adr0, adr1;
  wire  [7:0]  data0, data1;

  sram_port_ctrl dut (
    .CLOCK_50(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp0), .rsp_rdata(rd0),
    .busy(busy0), .sram_adrx(adr0), .sram_data(data0), .sram_nCS(ncs0),
    .sram_nOE(noe0), .sram_nWE(nwe0)
  );

  sram_port_ctrl #(.SETUP_CYC(3), .ACCESS_CYC(4)) dut_t (
    .CLOCK_50(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp1), .rsp_rdata(rd1),
    .busy(busy1), .sram_adrx(adr1), .sram_data(data1), .sram_nCS(ncs1),
    .sram_nOE(noe1), .sram_nWE(nwe1)
  );

  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  assign data0 = (!ncs0 && !noe0) ? mem0[adr0] : 8'bz;
  assign data1 = (!ncs1 && !noe1) ? mem1[adr1] : 8'bz;
  always @(posedge clk) begin
    if (!ncs0 && !nwe0) mem0[adr0] <= data0;
    if (!ncs1 && !nwe1) mem1[adr1] <= data1;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] p0, p1;
  assign p0 = {ncs0, noe0, nwe0, busy0, rdy0, dut.r_drive_en};
  assign p1 = {ncs1, noe1, nwe1, busy1, rdy1, dut_t.r_drive_en};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc + 1);
    end
  endtask

  function automatic logic [5:0] pins_now();
    return (sel == 1) ? p1 : p0;
  endfunction

  // Bus contention and strobe-overlap invariants, every cycle on both ports.
  always @(negedge clk) begin
    if (!rst) begin
      chk("invariant0", 32'(!(dut.r_drive_en && !noe0) && !(!noe0 && !nwe0)), 32'd1);
      chk("invariant1", 32'(!(dut_t.r_drive_en && !noe1) && !(!noe1 && !nwe1)), 32'd1);
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    exp_t e;
    if (rsp0) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rsp0_data", 32'(rd0), 32'(e.d));
        chk("rsp0_cycle", 32'(cyc + 1), 32'(e.c));
      end
    end
    if (rsp1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_data", 32'(rd1), 32'(e.d));
        chk("rsp1_cycle", 32'(cyc + 1), 32'(e.c));
      end
    end
  end

  // One transaction on the port picked by sel, pin pattern checked every busy cycle.
  task automatic do_req(input int s, input int a, input bit w, input logic [10:0] ad,
                        input logic [7:0] wd, input logic [7:0] rexp, input bit chaff,
                        input bit gap);
    int t, n;
    bit got;
    logic [5:0] e;
    n = s + a + 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pins_now()[1]) got = 1;
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    chk("idle_pins", 32'(pins_now()), 32'b111010);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = ad;
    req_wdata = wd;
    t = cyc + 1;
    if (gap) chk("accept_gap", 32'(t - last_t), 32'd5);
    last_t = t;
    if (!w) begin
      if (sel == 1) q1.push_back('{rexp, t + n});
      else          q0.push_back('{rexp, t + n});
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e = {1'b0, (w || k > s + a), !(w && k > s && k <= s + a), 1'b1, 1'b0, w};
      chk("busy_pins", 32'(pins_now()), 32'(e));
      chk("adrx", 32'((sel == 1) ? adr1 : adr0), 32'(ad));
      if (w) chk("bus_wdata", 32'((sel == 1) ? data1 : data0), 32'(wd));
      if (chaff && k < n) begin
        req_addr  = ad + 11'(k * 37);
        req_wdata = ~wd;
        req_write = !w;
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("reset_pins0", 32'(p0), 32'b111000);
    chk("reset_pins1", 32'(p1), 32'b111000);
    chk("reset_adrx", 32'(adr0), 32'd0);
    chk("reset_rsp", 32'({rsp0, rsp1}), 32'd0);
    chk("reset_rdata", 32'({rd0, rd1}), 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_release", 32'(rdy0), 32'd1);

    // Reset asserted in ACCESS of a write to 0x005.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h005; req_wdata = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_nwe_low", 32'(nwe0), 32'd0);
    rst = 1'b1;
    #1 chk("abort_pins", 32'(p0), 32'b111000);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready", 32'({rdy0, busy0}), 32'b10);

    // Single write then read back at defaults.
    do_req(1, 2, 1'b1, 11'h003, 8'h7C, 8'h00, 1'b0, 1'b0);
    chk("mem_003", 32'(mem0[3]), 32'h7C);
    do_req(1, 2, 1'b0, 11'h003, 8'h00, 8'h7C, 1'b0, 1'b1);

    // Back-to-back sweep: write 0x7F-i to i, then read everything back.
    for (int i = 0; i < 128; i++)
      do_req(1, 2, 1'b1, 11'(i), 8'(8'h7F - i), 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 128; i++)
      do_req(1, 2, 1'b0, 11'(i), 8'h00, 8'(8'h7F - i), 1'b0, 1'b1);

    // Requests held during a transaction must be ignored.
    do_req(1, 2, 1'b1, 11'h010, 8'h3C, 8'h00, 1'b1, 1'b0);
    chk("chaff_mem_035", 32'(mem0[11'h035]), 32'h4A);
    do_req(1, 2, 1'b0, 11'h010, 8'h00, 8'h3C, 1'b1, 1'b1);

    // Stretched timing on the second instance.
    sel = 1;
    do_req(3, 4, 1'b1, 11'h020, 8'h5A, 8'h00, 1'b0, 1'b0);
    chk("mem1_020", 32'(mem1[11'h020]), 32'h5A);
    do_req(3, 4, 1'b0, 11'h020, 8'h00, 8'h5A, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
